// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control package: FSM state encoding, default mul/div latency,
// per-cycle control cause and the cause -> enable/flush mapping.
package pipe_ctrl_pkg;

  localparam int unsigned MD_LAT_DEFAULT = 32;
  localparam int          MD_CNT_W       = 8;

  // state      | meaning
  // ST_RUN     | pipeline advancing, stalling or flushing on single-cycle events
  // ST_MD_BUSY | multi-cycle mul/div holds EX, md_cnt counts remaining hold cycles
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } pipe_state_e;

  // Winning event for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    CAUSE_RST      = 3'd0,
    CAUSE_DMEM     = 3'd1,
    CAUSE_MD       = 3'd2,
    CAUSE_REDIR    = 3'd3,
    CAUSE_LOAD_USE = 3'd4,
    CAUSE_IMEM     = 3'd5,
    CAUSE_NORM     = 3'd6
  } ctrl_cause_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  // Enables then flushes; a flush always wins over the enable of its register.
  function automatic ctrl_t ctrl_for(input ctrl_cause_e cause);
    ctrl_t c;
    c = 9'b11111_0000;
    case (cause)
      CAUSE_RST:      c = 9'b00000_1111;
      CAUSE_DMEM:     c = 9'b00001_0001;
      CAUSE_MD:       c = 9'b00001_0010;
      CAUSE_REDIR:    c = 9'b11111_1100;
      CAUSE_LOAD_USE: c = 9'b00111_0100;
      CAUSE_IMEM:     c = 9'b01111_1000;
      CAUSE_NORM:     c = 9'b11111_0000;
      default:        c = 9'b11111_0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detector: flags an ID source that reads the register a load
// in EX has not yet produced. Purely combinational.
module pipe_hazard_det #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  ex_load,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_live  = (rd_addr != '0);
  assign rs1_hit  = rs1_used && (rs1_addr == rd_addr);
  assign rs2_hit  = rs2_used && (rs2_addr == rd_addr);
  assign load_use = ex_load && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller with multi-cycle mul/div hold.
// Optional performance counters (stall_cnt, flush_cnt) under PIPE_CTRL_PERF_EN.
//
// state      | meaning
// ST_RUN     | normal operation, single-cycle hazards resolved combinationally
// ST_MD_BUSY | mul/div occupying EX; held until md_cnt reaches 0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = MD_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_load,
  input  logic                  ex_redirect,
  input  logic                  ex_md_start,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  // A one-cycle mul/div never needs a hold, so the start request is dropped.
  localparam bit MD_EN = (MD_LAT > 1);
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_EN ? MD_CNT_W'(MD_LAT - 2) : '0;

  pipe_state_e         state;
  pipe_state_e         state_nxt;
  logic [MD_CNT_W-1:0] md_cnt;
  logic [MD_CNT_W-1:0] md_cnt_nxt;
  ctrl_cause_e         cause;
  ctrl_t               ctrl;
  logic                load_use;

  pipe_hazard_det #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd_addr  (ex_rd_addr),
    .ex_load  (ex_load),
    .load_use (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    cause      = CAUSE_NORM;
    if (rst) begin
      cause = CAUSE_RST;
    end else if (dmem_busy) begin
      cause = CAUSE_DMEM;
    end else if (state == ST_MD_BUSY) begin
      // The final hold cycle lets the result advance; a new start is not taken here.
      if (md_cnt != '0) begin
        cause      = CAUSE_MD;
        md_cnt_nxt = md_cnt - 8'd1;
      end else begin
        cause     = CAUSE_NORM;
        state_nxt = ST_RUN;
      end
    end else if (MD_EN && ex_md_start) begin
      cause      = CAUSE_MD;
      state_nxt  = ST_MD_BUSY;
      md_cnt_nxt = MD_LOAD;
    end else if (ex_redirect) begin
      cause = CAUSE_REDIR;
    end else if (load_use) begin
      cause = CAUSE_LOAD_USE;
    end else if (!imem_ready) begin
      cause = CAUSE_IMEM;
    end
  end

  assign ctrl         = ctrl_for(cause);
  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc_en) stall_cnt <= stall_cnt + 32'd1;
      if (cause == CAUSE_REDIR) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MD_LAT=4 main instance, MD_LAT=1 side instance).
module tb_pipe_ctrl;

  localparam int AW = 5;

  // {pc, if_id, id_ex, ex_mem, mem_wb en | if_id, id_ex, ex_mem, mem_wb flush}
  localparam logic [8:0] E_NORM  = 9'b11111_0000;
  localparam logic [8:0] E_RST   = 9'b00000_1111;
  localparam logic [8:0] E_DMEM  = 9'b00001_0001;
  localparam logic [8:0] E_MD    = 9'b00001_0010;
  localparam logic [8:0] E_REDIR = 9'b11111_1100;
  localparam logic [8:0] E_LU    = 9'b00111_0100;
  localparam logic [8:0] E_IMEM  = 9'b01111_1000;
  localparam logic [8:0] M_ALL   = 9'b11111_1111;
  localparam logic [8:0] M_DMEM  = 9'b11110_1111;  // mem_wb_en is don't-care under its flush
  localparam logic [8:0] M_IMEM  = 9'b10111_1111;  // if_id_en is don't-care under its flush

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rs1, rs2, rd;
  logic          rs1_used, rs2_used, ex_load, ex_redirect, ex_md_start, imem_ready, dmem_busy;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1;
  logic if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_wb_flush1;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

  logic [8:0] got0, got1;
  assign got0 = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  assign got1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1,
                 if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_wb_flush1};

  pipe_ctrl #(.REG_ADDR_W(AW), .MD_LAT(4)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .ex_rd_addr(rd), .ex_load(ex_load), .ex_redirect(ex_redirect), .ex_md_start(ex_md_start),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_ctrl #(.REG_ADDR_W(AW), .MD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .ex_rd_addr(rd), .ex_load(ex_load), .ex_redirect(ex_redirect), .ex_md_start(ex_md_start),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1),
    .mem_wb_en(mem_wb_en1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .ex_mem_flush(ex_mem_flush1), .mem_wb_flush(mem_wb_flush1)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  typedef struct {
    logic          rst;
    logic [AW-1:0] rs1, rs2, rd;
    logic          rs1_used, rs2_used, ex_load, redirect, md_start, imem_ready, dmem_busy;
    logic [8:0]    exp, mask;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic redir, input logic md,
                              input logic im, input logic dm);
    vec_t v;
    v = '{r, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, redir, md, im, dm, E_NORM, M_ALL};
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, return at mid-cycle for sampling.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    rs1_used = v.rs1_used; rs2_used = v.rs2_used; ex_load = v.ex_load;
    ex_redirect = v.redirect; ex_md_start = v.md_start;
    imem_ready = v.imem_ready; dmem_busy = v.dmem_busy;
    #3;
  endtask

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp,
                     input logic [8:0] mask);
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (mask %b)", nm, got, exp, mask);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  int exmem_low;

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; ex_load = 1'b0; ex_redirect = 1'b0;
    ex_md_start = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;

    //            rst rs1    rs2    rd     u1 u2 ld rdr md im dm  exp      mask
    vecs[0]  = '{1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 1, 0, E_RST,   M_ALL};
    vecs[1]  = '{0, 5'd3,  5'd4,  5'd9,  1, 1, 0, 0, 0, 1, 0, E_NORM,  M_ALL};
    vecs[2]  = '{0, 5'd5,  5'd0,  5'd5,  1, 0, 1, 0, 0, 1, 0, E_LU,    M_ALL};
    vecs[3]  = '{0, 5'd0,  5'd0,  5'd0,  1, 1, 1, 0, 0, 1, 0, E_NORM,  M_ALL};
    vecs[4]  = '{0, 5'd5,  5'd0,  5'd5,  0, 0, 1, 0, 0, 1, 0, E_NORM,  M_ALL};
    vecs[5]  = '{0, 5'd1,  5'd7,  5'd7,  1, 1, 1, 0, 0, 1, 0, E_LU,    M_ALL};
    vecs[6]  = '{0, 5'd5,  5'd5,  5'd5,  1, 1, 0, 0, 0, 1, 0, E_NORM,  M_ALL};
    vecs[7]  = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 0, E_IMEM,  M_IMEM};
    vecs[8]  = '{0, 5'd5,  5'd0,  5'd5,  1, 0, 1, 1, 0, 0, 0, E_REDIR, M_ALL};
    vecs[9]  = '{0, 5'd5,  5'd0,  5'd5,  1, 0, 1, 0, 0, 0, 0, E_LU,    M_ALL};
    vecs[10] = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 0, 1, 1, E_DMEM,  M_DMEM};
    vecs[11] = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 1, 1, 1, E_DMEM,  M_DMEM};
    vecs[12] = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 1, 0, E_NORM,  M_ALL};
    vecs[13] = '{1, 5'd5,  5'd0,  5'd5,  1, 0, 1, 1, 1, 0, 1, E_RST,   M_ALL};
    vecs[14] = '{0, 5'd31, 5'd0,  5'd31, 1, 0, 1, 0, 0, 1, 0, E_LU,    M_ALL};
    vecs[15] = '{0, 5'd0,  5'd0,  5'd0,  1, 1, 1, 0, 0, 0, 0, E_IMEM,  M_IMEM};

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d", i), got0, vecs[i].exp, vecs[i].mask);
      chk($sformatf("vec%0d_lat1", i), got1, vecs[i].exp, vecs[i].mask);
    end

    // Mul/div hold, MD_LAT=4: three held cycles then one advance; restart ignored on release.
    exmem_low = 0;
    apply(mk(0, 0, 1, 1, 0)); chk("md_c0", got0, E_MD, M_ALL);
    chk("md_lat1_ignored", got1, E_NORM, M_ALL);
    if (!ex_mem_en) exmem_low++;
    apply(mk(0, 1, 0, 1, 0)); chk("md_c1_over_redir", got0, E_MD, M_ALL);
    if (!ex_mem_en) exmem_low++;
    apply(mk(0, 0, 0, 1, 0)); chk("md_c2", got0, E_MD, M_ALL);
    if (!ex_mem_en) exmem_low++;
    apply(mk(0, 0, 1, 1, 0)); chk("md_c3_release", got0, E_NORM, M_ALL);
    chk("md_lat1_c3", got1, E_NORM, M_ALL);
    if (!ex_mem_en) exmem_low++;
    apply(mk(0, 0, 0, 1, 0)); chk("md_c4_run", got0, E_NORM, M_ALL);
    if (!ex_mem_en) exmem_low++;
    chk_int("md_hold_cycles", exmem_low, 3);

    // dmem_busy during MD_BUSY freezes md_cnt, delaying release by three cycles.
    apply(mk(0, 0, 1, 1, 0)); chk("mdd_c0", got0, E_MD, M_ALL);
    apply(mk(0, 0, 0, 1, 0)); chk("mdd_c1", got0, E_MD, M_ALL);
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 0, 1, 1));
      chk($sformatf("mdd_dmem%0d", k), got0, E_DMEM, M_DMEM);
    end
    apply(mk(0, 0, 0, 1, 0)); chk("mdd_c5_still_held", got0, E_MD, M_ALL);
    apply(mk(0, 0, 0, 1, 0)); chk("mdd_c6_release", got0, E_NORM, M_ALL);
    apply(mk(0, 0, 0, 1, 0)); chk("mdd_c7_run", got0, E_NORM, M_ALL);

    // Reset in the middle of MD_BUSY aborts it.
    apply(mk(0, 0, 1, 1, 0)); chk("mdr_c0", got0, E_MD, M_ALL);
    apply(mk(0, 0, 0, 1, 0)); chk("mdr_c1", got0, E_MD, M_ALL);
    apply(mk(1, 0, 0, 1, 0)); chk("mdr_rst", got0, E_RST, M_ALL);
    apply(mk(0, 0, 0, 1, 0)); chk("mdr_after", got0, E_NORM, M_ALL);
    apply(mk(0, 1, 0, 1, 0)); chk("mdr_redir_in_run", got0, E_REDIR, M_ALL);

`ifdef PIPE_CTRL_PERF_EN
    apply(mk(1, 0, 0, 1, 0));
    for (int k = 0; k < 10; k++) apply(mk(0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) apply(mk(0, 1, 0, 1, 0));
    apply(mk(0, 0, 0, 1, 0));
    chk_int("stall_cnt", int'(stall_cnt), 10);
    chk_int("flush_cnt", int'(flush_cnt), 2);
    chk_int("stall_cnt_lat1", int'(stall_cnt1), 10);
    chk_int("flush_cnt_lat1", int'(flush_cnt1), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
